// File: rtl/arb_pkg.sv
// Shared definitions for the shared-bus arbitration slice: client count,
// bus width defaults, requester state encoding and the command record.
package arb_pkg;

  localparam int NUM_CLIENTS    = 8;
  localparam int BIT_CLIENTS    = $clog2(NUM_CLIENTS);
  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_MAX_BURST  = 16;
  localparam int BUS_LEN_W      = $clog2(BUS_MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    COOL = 2'd2
  } state_e;

  typedef struct packed {
    logic                      we;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_LEN_W-1:0]      len;
  } cmd_t;

endpackage

// File: rtl/arbitration_requester.sv
// One requester port of the round-robin shared bus. Latches a burst command,
// requests the bus, moves beats only while granted, then drops the request
// for one cycle so the arbiter rotates. Tracks starvation with a sticky flag.
module arbitration_requester
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int MAX_BURST  = BUS_MAX_BURST,
  parameter int TIMEOUT    = 1024,
  localparam int LEN_W     = $clog2(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  request,
  input  logic                  grant,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy,
  output logic                  timeout
);

  localparam int CNT_W = LEN_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  fire_s;
  logic                  last_s;

  // A beat is offered only while granted in BUSY; writes also need data.
  assign bus_valid = (state_q == BUSY) & grant & (~we_q | wr_valid);
  assign fire_s    = bus_valid & bus_ready;
  assign last_s    = (beat_q == {1'b0, len_q});

  assign bus_addr  = addr_q + ADDR_WIDTH'(beat_q);
  assign bus_we    = we_q;
  assign bus_wdata = wr_data;
  assign wr_ready  = fire_s & we_q;
  assign cmd_ready = (state_q == IDLE);
  assign request   = (state_q == BUSY);
  assign busy      = (state_q != IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign timeout   = timeout_q;

  // Next-state logic: command latch, beat stepping, starvation counting.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d      = cmd_we;
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          beat_d    = '0;
          to_cnt_d  = '0;
          timeout_d = 1'b0;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (fire_s) begin
          to_cnt_d = '0;
          if (!we_q) begin
            rd_data_d  = bus_rdata;
            rd_valid_d = 1'b1;
          end else begin
            rd_valid_d = 1'b0;
          end
          if (last_s) begin
            state_d = COOL;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end else begin
          // Saturate so the sticky flag cannot be lost to wrap-around.
          if (to_cnt_q != TO_W'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end else begin
            to_cnt_d = to_cnt_q;
          end
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; a burst in flight
  // is simply abandoned on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_arbitration_requester.sv
// Directed bench for arbitration_requester: a scoreboard queue holds the
// beats each command should produce; beats and read returns are popped and
// compared as the DUT presents them. Two instances share a small round-robin
// grant model for the contention scenario.
module tb_arbitration_requester;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_we;
  logic [3:0]  cmd_len;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        bus_ready;
  logic [63:0] bus_rdata;
  logic        grant_drv;
  logic        rr_mode;
  logic        last_g = 1'b1;

  logic        cmd_valid0, cmd_ready0, wr_ready0, rd_valid0, request0, grant0;
  logic        bus_valid0, bus_we0, busy0, timeout0;
  logic [31:0] cmd_addr0, bus_addr0;
  logic [63:0] rd_data0, bus_wdata0;

  logic        cmd_valid1, cmd_ready1, wr_ready1, rd_valid1, request1, grant1;
  logic        bus_valid1, bus_we1, busy1, timeout1;
  logic [31:0] cmd_addr1, bus_addr1;
  logic [63:0] rd_data1, bus_wdata1;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       q0[$];
  beat_t       q1[$];
  logic [63:0] rdq[$];
  logic        rd_due = 1'b0;

  always #5 clk = ~clk;

  // Round-robin grant model used only while rr_mode is set.
  wire rr_g0 = request0 & (~request1 | last_g);
  wire rr_g1 = request1 & (~request0 | ~last_g);
  assign grant0 = rr_mode ? rr_g0 : grant_drv;
  assign grant1 = rr_mode ? rr_g1 : 1'b0;
  always @(posedge clk) begin
    if (grant0) last_g <= 1'b0;
    else if (grant1) last_g <= 1'b1;
  end

  arbitration_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(16), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr0), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready0), .rd_data(rd_data0), .rd_valid(rd_valid0), .request(request0),
    .grant(grant0), .bus_valid(bus_valid0), .bus_we(bus_we0), .bus_addr(bus_addr0),
    .bus_wdata(bus_wdata0), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy0),
    .timeout(timeout0));

  arbitration_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(16), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr1), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready1), .rd_data(rd_data1), .rd_valid(rd_valid1), .request(request1),
    .grant(grant1), .bus_valid(bus_valid1), .bus_we(bus_we1), .bus_addr(bus_addr1),
    .bus_wdata(bus_wdata1), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy1),
    .timeout(timeout1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd0(input logic we, input logic [31:0] addr, input logic [3:0] len,
                      input int nbeats);
    beat_t b;
    cmd_valid0 = 1'b1; cmd_we = we; cmd_addr0 = addr; cmd_len = len;
    for (int i = 0; i < nbeats; i++) begin
      b.we = we; b.addr = addr + 32'(i);
      q0.push_back(b);
    end
  endtask

  // One clock: settle, score whatever the buses show, advance past the edge.
  task automatic cyc();
    beat_t b;
    #1;
    check("rd_valid0", {63'd0, rd_valid0}, {63'd0, rd_due});
    if (rd_due && rdq.size() > 0) check("rd_data0", rd_data0, rdq.pop_front());
    rd_due = 1'b0;
    if (bus_valid0 && bus_ready) begin
      if (q0.size() == 0) check("spurious_beat0", {63'd0, bus_valid0}, 64'd0);
      else begin
        b = q0.pop_front();
        check("bus_addr0", {32'd0, bus_addr0}, {32'd0, b.addr});
        check("bus_we0", {63'd0, bus_we0}, {63'd0, b.we});
        check("wr_ready0", {63'd0, wr_ready0}, {63'd0, b.we});
        if (b.we) check("bus_wdata0", bus_wdata0, wr_data);
        else if (!rst) begin rdq.push_back(bus_rdata); rd_due = 1'b1; end
      end
    end else check("wr_ready0_idle", {63'd0, wr_ready0}, 64'd0);
    if (bus_valid1 && bus_ready) begin
      if (q1.size() == 0) check("spurious_beat1", {63'd0, bus_valid1}, 64'd0);
      else begin
        b = q1.pop_front();
        check("bus_addr1", {32'd0, bus_addr1}, {32'd0, b.addr});
        check("wr_ready1", {63'd0, wr_ready1}, {63'd0, b.we});
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t b;
    rst = 1'b1; cmd_we = 1'b0; cmd_len = 4'd0; wr_data = 64'd0; wr_valid = 1'b0;
    bus_ready = 1'b0; bus_rdata = 64'd0; grant_drv = 1'b0; rr_mode = 1'b0;
    cmd_valid0 = 1'b0; cmd_addr0 = 32'd0; cmd_valid1 = 1'b0; cmd_addr1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    check("rst_cmd_ready", {63'd0, cmd_ready0}, 64'd1);
    check("rst_request", {63'd0, request0}, 64'd0);
    check("rst_bus_valid", {63'd0, bus_valid0}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid0}, 64'd0);
    check("rst_rd_data", rd_data0, 64'd0);
    check("rst_timeout", {63'd0, timeout0}, 64'd0);
    check("rst_busy", {63'd0, busy0}, 64'd0);

    // 1: single write, grant tied high
    grant_drv = 1'b1; bus_ready = 1'b1; wr_valid = 1'b1; wr_data = 64'h1111_2222_3333_4444;
    cmd0(1'b1, 32'h100, 4'd0, 1);
    cyc();
    cmd_valid0 = 1'b0;
    check("t1_bus_valid", {63'd0, bus_valid0}, 64'd1);
    check("t1_bus_addr", {32'd0, bus_addr0}, 64'h100);
    check("t1_request", {63'd0, request0}, 64'd1);
    check("t1_cmd_ready_busy", {63'd0, cmd_ready0}, 64'd0);
    cyc();
    check("t1_request_cool", {63'd0, request0}, 64'd0);
    check("t1_cmd_ready_cool", {63'd0, cmd_ready0}, 64'd0);
    cyc();
    check("t1_cmd_ready_idle", {63'd0, cmd_ready0}, 64'd1);

    // 2: read burst of 4
    wr_valid = 1'b0;
    cmd0(1'b0, 32'h40, 4'd3, 4);
    cyc();
    cmd_valid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_rdata = 64'hC0DE_0000_0000_0000 + 64'(i);
      check("t2_bus_valid", {63'd0, bus_valid0}, 64'd1);
      cyc();
    end
    cyc();
    cyc();
    check("t2_drain", 64'(q0.size() + rdq.size()), 64'd0);

    // 3: two requesters contending under round-robin
    rr_mode = 1'b1; wr_valid = 1'b1; wr_data = 64'h5555_0000_AAAA_0000;
    cmd0(1'b1, 32'h1000, 4'd3, 4);
    cmd_valid1 = 1'b1; cmd_addr1 = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      b.we = 1'b1; b.addr = 32'h2000 + 32'(i);
      q1.push_back(b);
    end
    cyc();
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t3_alternate", {63'd0, bus_valid0 ^ bus_valid1}, 64'd1);
      cyc();
    end
    check("t3_done_req0", {63'd0, request0}, 64'd0);
    check("t3_done_req1", {63'd0, request1}, 64'd0);
    check("t3_drain", 64'(q0.size() + q1.size()), 64'd0);
    cyc();
    rr_mode = 1'b0;

    // 4: write burst with a two-cycle data gap
    grant_drv = 1'b1; wr_valid = 1'b1; wr_data = 64'h0000_0000_0000_0200;
    cmd0(1'b1, 32'h200, 4'd2, 3);
    cyc();
    cmd_valid0 = 1'b0;
    cyc();
    wr_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_gap_bus_valid", {63'd0, bus_valid0}, 64'd0);
      check("t4_gap_request", {63'd0, request0}, 64'd1);
      cyc();
    end
    wr_valid = 1'b1; wr_data = 64'h0000_0000_0000_0201;
    cyc();
    wr_data = 64'h0000_0000_0000_0202;
    cyc();
    check("t4_drain", 64'(q0.size()), 64'd0);
    check("t4_request_cool", {63'd0, request0}, 64'd0);
    cyc();

    // 5: starvation flag with TIMEOUT=8
    grant_drv = 1'b0; wr_valid = 1'b0;
    cmd0(1'b0, 32'h300, 4'd0, 1);
    cyc();
    cmd_valid0 = 1'b0;
    repeat (7) cyc();
    check("t5_timeout_before", {63'd0, timeout0}, 64'd0);
    cyc();
    check("t5_timeout_set", {63'd0, timeout0}, 64'd1);
    repeat (3) cyc();
    check("t5_timeout_sticky", {63'd0, timeout0}, 64'd1);
    grant_drv = 1'b1; bus_rdata = 64'h0000_0000_0000_0300;
    cyc();
    grant_drv = 1'b0;
    cyc();
    check("t5_timeout_after_done", {63'd0, timeout0}, 64'd1);
    cyc();
    grant_drv = 1'b1; bus_rdata = 64'h0000_0000_0000_0310;
    cmd0(1'b0, 32'h310, 4'd0, 1);
    cyc();
    cmd_valid0 = 1'b0;
    check("t5_timeout_cleared", {63'd0, timeout0}, 64'd0);
    repeat (3) cyc();

    // 6: reset in the middle of a read burst
    cmd0(1'b0, 32'h500, 4'd5, 3);
    cyc();
    cmd_valid0 = 1'b0;
    bus_rdata = 64'h0000_0000_0000_0500;
    cyc();
    bus_rdata = 64'h0000_0000_0000_0501;
    cyc();
    check("t6_beat2_addr", {32'd0, bus_addr0}, 64'h502);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_request", {63'd0, request0}, 64'd0);
    check("t6_bus_valid", {63'd0, bus_valid0}, 64'd0);
    check("t6_rd_valid", {63'd0, rd_valid0}, 64'd0);
    check("t6_cmd_ready", {63'd0, cmd_ready0}, 64'd1);
    check("t6_rd_data", rd_data0, 64'd0);
    bus_rdata = 64'h0000_0000_0000_0600;
    cmd0(1'b0, 32'h600, 4'd1, 2);
    cyc();
    cmd_valid0 = 1'b0;
    cyc();
    bus_rdata = 64'h0000_0000_0000_0601;
    cyc();
    cyc();
    cyc();
    check("final_drain", 64'(q0.size() + q1.size() + rdq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
